// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 op codes,
// FSM state encoding and small op-decode helpers.
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } mdu_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_iter_unit_operand_prep.sv
// Combinational operand conditioning used at the accept edge: operand
// magnitudes, result sign flags and detection of the two division corner cases.
module mdu_operand_prep
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic            neg_result,
  output logic            neg_rem,
  output logic            div_by_zero,
  output logic            signed_overflow
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic sign_a;
  logic sign_b;

  assign sign_a = is_signed_a(op) & rs1[XLEN-1];
  assign sign_b = is_signed_b(op) & rs2[XLEN-1];

  assign mag_a = sign_a ? -rs1 : rs1;
  assign mag_b = sign_b ? -rs2 : rs2;

  assign div_by_zero     = is_div(op) & (rs2 == '0);
  assign signed_overflow = is_div(op) & is_signed_a(op) & (rs1 == MOST_NEG) & (rs2 == '1);

  // A zero divisor yields an all-ones quotient regardless of operand signs.
  assign neg_result = (sign_a ^ sign_b) & ~div_by_zero;
  assign neg_rem    = sign_a;

endmodule

// File: rtl/mdu_iter_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: shift-add multiplier retiring
// MUL_STEP bits per cycle and a restoring radix-2 divider, valid/ready on both sides.
module mdu_iter_unit
  import mdu_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int MUL_STEP     = 4,
  parameter int FAST_SPECIAL = 1
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            flush,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [4:0]      in_rd,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] MUL_ITERS = CNT_W'(XLEN / MUL_STEP);
  localparam logic [CNT_W-1:0] DIV_ITERS = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mdu_state_e state_reg, state_next;

  logic [2:0]        op_reg;
  logic [4:0]        rd_reg;
  logic              neg_res_reg;
  logic              neg_rem_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [2*XLEN-1:0] mcand_reg;
  logic [XLEN-1:0]   mplier_reg;
  logic [XLEN:0]     rem_reg;
  logic [XLEN-1:0]   quo_reg;
  logic [XLEN-1:0]   dvsr_reg;
  logic [XLEN-1:0]   res_reg;

  logic [XLEN-1:0] mag_a, mag_b;
  logic            neg_result, neg_rem, div_by_zero, signed_overflow;

  mdu_operand_prep #(.XLEN(XLEN)) u_prep (
    .op              (in_op),
    .rs1             (in_rs1_data),
    .rs2             (in_rs2_data),
    .mag_a           (mag_a),
    .mag_b           (mag_b),
    .neg_result      (neg_result),
    .neg_rem         (neg_rem),
    .div_by_zero     (div_by_zero),
    .signed_overflow (signed_overflow)
  );

  logic accept;
  logic take_fast;

  assign in_rdy    = (state_reg == IDLE) & ~flush;
  assign accept    = in_vld & in_rdy;
  assign take_fast = (FAST_SPECIAL != 0) & (div_by_zero | signed_overflow);

  // Architectural results of the corner cases; overflow quotient is rs1 itself.
  logic [XLEN-1:0] special_result;
  always_comb begin
    special_result = '0;
    if (div_by_zero) begin
      special_result = is_rem(in_op) ? in_rs1_data : '1;
    end else if (!is_rem(in_op)) begin
      special_result = in_rs1_data;
    end
  end

  // Partial products for one multiplier slice.
  logic [2*XLEN-1:0] pp [MUL_STEP];
  logic [2*XLEN-1:0] partial;

  for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
    assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
  end

  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      partial = partial + pp[j];
    end
  end

  // Restoring step: shift next dividend bit into the remainder, trial-subtract.
  logic [XLEN+1:0] div_trial;
  logic [XLEN+1:0] div_diff;
  logic            div_ok;

  assign div_trial = {rem_reg, quo_reg[XLEN-1]};
  assign div_diff  = div_trial - {2'b00, dvsr_reg};
  assign div_ok    = ~div_diff[XLEN+1];

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_mag;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_result;

  assign prod_fix = neg_res_reg ? -acc_reg : acc_reg;
  assign quo_fix  = neg_res_reg ? -quo_reg : quo_reg;
  assign rem_mag  = rem_reg[XLEN-1:0];
  assign rem_fix  = neg_rem_reg ? -rem_mag : rem_mag;

  always_comb begin
    fix_result = '0;
    case (op_reg)
      MDU_MUL:                          fix_result = prod_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU:  fix_result = prod_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:                fix_result = quo_fix;
      default:                          fix_result = rem_fix;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (take_fast)           state_next = DONE;
          else if (is_div(in_op))  state_next = DIV;
          else                     state_next = MUL;
        end
      end
      MUL:     if (cnt_reg == CNT_ONE) state_next = FIX;
      DIV:     if (cnt_reg == CNT_ONE) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    if (out_rdy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      op_reg      <= '0;
      rd_reg      <= '0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      dvsr_reg    <= '0;
      res_reg     <= '0;
    end else if (accept) begin
      op_reg      <= in_op;
      rd_reg      <= in_rd;
      neg_res_reg <= neg_result;
      neg_rem_reg <= neg_rem;
      cnt_reg     <= is_div(in_op) ? DIV_ITERS : MUL_ITERS;
      acc_reg     <= '0;
      mcand_reg   <= {{XLEN{1'b0}}, mag_a};
      mplier_reg  <= mag_b;
      rem_reg     <= '0;
      quo_reg     <= mag_a;
      dvsr_reg    <= mag_b;
      res_reg     <= special_result;
    end else begin
      case (state_reg)
        MUL: begin
          acc_reg    <= acc_reg + partial;
          mcand_reg  <= mcand_reg << MUL_STEP;
          mplier_reg <= mplier_reg >> MUL_STEP;
          cnt_reg    <= cnt_reg - CNT_ONE;
        end
        DIV: begin
          rem_reg <= div_ok ? div_diff[XLEN:0] : div_trial[XLEN:0];
          quo_reg <= {quo_reg[XLEN-2:0], div_ok};
          cnt_reg <= cnt_reg - CNT_ONE;
        end
        FIX:     res_reg <= fix_result;
        default: ;
      endcase
    end
  end

  assign out_vld  = (state_reg == DONE);
  assign out_data = out_vld ? res_reg : '0;
  assign out_rd   = out_vld ? rd_reg : '0;
  assign busy     = (state_reg != IDLE);

endmodule

// File: doc/mdu_iter_unit.md
Name: mdu_iter_unit

Overview:
Parametrised, multi-cycle RV32M/RV64M multiply/divide execute unit. It sits beside the single-cycle ALU in the execute stage and takes decoded operands (already forwarded) under a valid/ready handshake. It returns the result and destination register to the LSU/writeback path, also under valid/ready. The unit is flushable by branch misprediction.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- MUL_STEP, 4, multiplier bits retired per iteration cycle; legal values 1, 2, 4, 8; must divide XLEN.
- FAST_SPECIAL, 1, when 1, divide-by-zero and signed overflow complete without iterating.

Ports:
- CLK  input  1  clock
- RSTN  input  1  reset, asynchronous, active-low
- flush  input  1  discard the in-flight op; synchronous
- in_vld  input  1  operation request
- in_rdy  output  1  unit can accept; equals (state==IDLE) & ~flush
- in_op  input  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- in_rs1_data  input  XLEN  operand A (dividend / multiplicand)
- in_rs2_data  input  XLEN  operand B (divisor / multiplier)
- in_rd  input  5  destination register
- out_vld  output  1  result valid
- out_rdy  input  1  consumer accepts the result
- out_data  output  XLEN  result
- out_rd  output  5  destination register of the result
- busy  output  1  state != IDLE

Behaviour:
- Reset: state IDLE; out_vld, out_data, out_rd, busy all 0; internal registers 0. Reset mid-operation abandons the op with no output.
- Accept: in_vld & in_rdy at a rising edge. At that edge the unit captures op, rd, operand magnitudes, and the result-sign flag.
  - Signed operands: MULH rs1 and rs2; MULHSU rs1 only; DIV/REM both.
  - Quotient sign = sA ^ sB. Remainder sign = sA.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
  - IDLE -> MUL for ops 0-3.
  - IDLE -> DIV for ops 4-7.
  - IDLE -> DONE directly for special cases when FAST_SPECIAL=1.
  - MUL -> FIX after XLEN/MUL_STEP iterations.
  - DIV -> FIX after XLEN iterations.
  - FIX -> DONE.
  - DONE -> IDLE on out_rdy.
- MUL datapath: 2*XLEN accumulator. Each cycle adds (mcand << k) * multiplier-slice over MUL_STEP bits (shift-add). In FIX, negate the full 2*XLEN product if the sign flag is set. MUL selects the low XLEN bits; MULH/MULHSU/MULHU select the high XLEN bits.
- DIV datapath: restoring radix-2, 1 quotient bit per cycle. Remainder register is XLEN+1 bits. In FIX, negate quotient/remainder per the sign flags.
- Latency, counted from the accept edge to out_vld high: MUL = XLEN/MUL_STEP+2 cycles (10 at defaults); DIV = XLEN+2 cycles (34); special case = 1 cycle.
- Special cases, results are always architecturally correct:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give rs1.
  - DIV with rs1 = most-negative and rs2 = -1: quotient = most-negative; REM = 0.
  - When FAST_SPECIAL=0 these iterate normally but must yield the same values.
- DONE: out_vld=1; out_data and out_rd are held stable until out_rdy. The cycle after the handshake: out_vld=0, state IDLE. There is no accept in the same cycle as DONE (in_rdy=0).
- out_data and out_rd are zero outside DONE.
- flush: highest priority. Next edge forces IDLE, out_vld=0, out_data/out_rd=0. A simultaneous in_vld is not accepted. flush during DONE with out_rdy=1 drops the result (the consumer must treat it as not transferred).
- Operand inputs are don't-care outside the accept edge.

Decomposition:
- Shared package mdu_pkg holds:
  - op localparams (MDU_MUL..MDU_REMU), the FSM state encoding, and helper functions is_div(op) and is_signed_a/b(op).
- Natural combinational sub-module mdu_operand_prep:
  - Inputs: op and operands. Outputs: magnitudes |A|, |B|, neg_result flag, neg_rem flag, div_by_zero, signed_overflow.
  - Used at the accept edge only.

Test Plan:
- MUL 7 x -3 (0xFFFFFFFD): out_data=0xFFFFFFEB exactly 10 cycles after accept. Repeat MUL_STEP=1: 34 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD and REM -7%2 -> 0xFFFFFFFF, each at 34 cycles; DIVU 100/7 -> 14, REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF, REMU 5%0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0. All at latency 1 with FAST_SPECIAL=1, and at latency 34 with identical values when FAST_SPECIAL=0.
- Backpressure: hold out_rdy=0 for 5 cycles in DONE -> out_vld, out_data and out_rd stay stable and in_rdy=0. Release -> out_vld=0 next cycle, in_rdy=1.
- flush in the 3rd DIV iteration, with in_vld=1 held -> next cycle IDLE, no out_vld, op not accepted. The following cycle accepts a new MUL; RSTN low mid-MUL -> all outputs 0 immediately.
